// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DWORD_BYTES     = 8;
  localparam int ALIGN_BITS      = 3;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte storage, one aligned doubleword per access, strobed write
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_W-ALIGN_BITS-1:0] waddr,
  input  logic [8*DWORD_BYTES-1:0]     wdata,
  input  logic [DWORD_BYTES-1:0]       wstrb,
  input  logic [ADDR_W-ALIGN_BITS-1:0] raddr,
  output logic [8*DWORD_BYTES-1:0]     rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Addresses are doubleword indices; the byte lane supplies the low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < DWORD_BYTES; b++) begin
        if (wstrb[b]) begin
          mem[{waddr, ALIGN_BITS'(b)}] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < DWORD_BYTES; b++) begin
      rdata[8*b +: 8] = mem[{raddr, ALIGN_BITS'(b)}];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder; DMEM_WSTRB_EN adds req_wstrb byte strobes
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_WSTRB_EN
  input  logic [7:0]        req_wstrb,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                accept, commit;

  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [7:0]          lat_wstrb;
  logic [7:0]          live_wstrb;

  logic                c_write, c_misalign;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic [7:0]          c_wstrb;
  logic [DATA_W-1:0]   arr_rdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

`ifdef DMEM_WSTRB_EN
  assign live_wstrb = req_wstrb;
`else
  assign live_wstrb = 8'hFF;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A single-cycle latency commits on the accept edge, before the latch holds anything.
  always_comb begin
    if (state_q == IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wstrb = live_wstrb;
    end else begin
      c_write = lat_write;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      c_wstrb = lat_wstrb;
    end
    c_misalign = (c_addr[ALIGN_BITS-1:0] != '0);
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (commit && c_write && !c_misalign),
    .waddr (c_addr[ADDR_W-1:ALIGN_BITS]),
    .wdata (c_wdata),
    .wstrb (c_wstrb),
    .raddr (c_addr[ADDR_W-1:ALIGN_BITS]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wstrb <= live_wstrb;
        cnt_q     <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        err_q   <= c_misalign;
        rdata_q <= (c_write || c_misalign) ? '0 : arr_rdata;
      end else if (state_q == RESP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  wstrb_drv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W  (10),
    .DATA_W  (64),
    .LATENCY (2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_WSTRB_EN
    .req_wstrb (wstrb_drv),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Stimulus only: issues one request with rsp_ready assumed high, returns response and latency.
  task automatic do_txn(input logic wr, input logic [9:0] a, input logic [63:0] wd,
                        input logic [7:0] strb, output logic [63:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    wstrb_drv = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    logic er;
    int lat;
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    wstrb_drv = 8'hFF;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    do_txn(1'b0, 10'h010, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL load_cleared: got %h want 0", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_cleared_lat: got %0d want 2", lat); end
  endtask

  task automatic test_store_load();
    logic [63:0] rd;
    logic er;
    int lat;
    do_txn(1'b1, 10'h008, 64'h1122334455667788, 8'hFF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_lat: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", er); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
    do_txn(1'b0, 10'h008, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_lat: got %0d want 2", lat); end
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL load_data: got %h want 1122334455667788", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", er); end
    checks++; if (u_dut.u_array.mem[8] !== 8'h88) begin errors++; $display("FAIL byte_lo: got %h want 88", u_dut.u_array.mem[8]); end
    checks++; if (u_dut.u_array.mem[15] !== 8'h11) begin errors++; $display("FAIL byte_hi: got %h want 11", u_dut.u_array.mem[15]); end
  endtask

  task automatic test_misaligned();
    logic [63:0] rd;
    logic er;
    int lat;
    do_txn(1'b0, 10'h00C, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", er); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_lat: got %0d want 2", lat); end
    do_txn(1'b1, 10'h009, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_store_err: got %b want 1", er); end
    do_txn(1'b0, 10'h008, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL after_misalign: got %h want 1122334455667788", rd); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd;
    logic er;
    int lat;
    int n;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 10'h008;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rsp_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL bp_first: got %h want 1122334455667788", rsp_rdata); end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h040;
    req_wdata = 64'h000000000000AAAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want 1122334455667788", i, rsp_rdata); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accepted: got %b want 0", req_ready); end
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_second_rsp: got %b want 1", rsp_valid); end
    @(posedge clk);
    do_txn(1'b0, 10'h040, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (rd !== 64'h000000000000AAAA) begin errors++; $display("FAIL bp_store_data: got %h want 000000000000aaaa", rd); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd;
    logic er;
    int lat;
    int accepts;
    logic [63:0] pat [3];
    pat[0] = 64'h0123456789ABCDEF;
    pat[1] = 64'hFEDCBA9876543210;
    pat[2] = 64'h00FF00FF00FF00FF;
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b1, 10'h100 + 10'(8 * i), pat[i], 8'hFF, rd, er, lat);
    end
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, 10'h100 + 10'(8 * i), 64'h0, 8'hFF, rd, er, lat);
      checks++; if (rd !== pat[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd, pat[i]); end
    end
    accepts = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 10'h100;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) accepts++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (accepts !== 3) begin errors++; $display("FAIL b2b_throughput: got %0d accepts want 3", accepts); end
    @(posedge clk);
  endtask

`ifdef DMEM_WSTRB_EN
  task automatic test_wstrb();
    logic [63:0] rd;
    logic er;
    int lat;
    do_txn(1'b1, 10'h030, 64'hFFFFFFFFFFFFFFFF, 8'h0F, rd, er, lat);
    do_txn(1'b0, 10'h030, 64'h0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h00000000FFFFFFFF) begin errors++; $display("FAIL wstrb_partial: got %h want 00000000ffffffff", rd); end
    do_txn(1'b1, 10'h030, 64'h1234123412341234, 8'h00, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wstrb_zero_err: got %b want 0", er); end
    do_txn(1'b0, 10'h030, 64'h0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h00000000FFFFFFFF) begin errors++; $display("FAIL wstrb_zero: got %h want 00000000ffffffff", rd); end
  endtask
`endif

  task automatic test_reset_abort();
    logic [63:0] rd;
    logic er;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h020;
    req_wdata = 64'h000000000000DEAD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL abort_rsp_rdata: got %h want 0", rsp_rdata); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_txn(1'b0, 10'h020, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL abort_no_write: got %h want 0", rd); end
    do_txn(1'b0, 10'h008, 64'h0, 8'hFF, rd, er, lat);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL abort_mem_cleared: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
`ifdef DMEM_WSTRB_EN
    test_wstrb();
`endif
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port: accepts load/store requests over a valid/ready handshake and returns read data or a store acknowledge after a programmable access latency.
- Replaces the zero-latency data memory, so the pipeline can be exercised against realistic multi-cycle memory behaviour.
- Holds little-endian, byte-addressed storage of 64-bit doublewords.

Parameters:
- ADDR_W, 10, byte-address width; storage depth = 2**ADDR_W bytes.
- DATA_W, 64, data width; fixed at 64 (8 bytes per access).
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_W  load data; 0 for stores and errors.
- rsp_err  output  1  misaligned access flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency counter = 0; latched request registers cleared.
  - Storage cleared to zero.
- A reset arriving mid-transaction aborts it. A store whose commit edge has not occurred is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch write/addr/wdata.
  - If LATENCY==1, go to RESP directly. Otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==0, go to RESP.
- Commit edge (the transition into RESP):
  - Store writes 8 bytes at addr..addr+7, little-endian (wdata[7:0] at addr).
  - Load samples the same 8 bytes into rsp_rdata.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready=0 throughout RESP, so there is no same-cycle overlap of response and new request.
- Latency: with rsp_ready held at 1, rsp_valid rises exactly LATENCY cycles after the accept edge. Throughput is one transaction per LATENCY+1 cycles.
- Misalignment (req_addr[2:0] != 0):
  - No storage access.
  - Response delivered with the same latency, rsp_err=1, rsp_rdata=0.
- Top-of-memory: an aligned address always fits within 2**ADDR_W, so there is no wrap-around case.
- Inputs are ignored outside IDLE. A req_valid held during WAIT/RESP is accepted only after returning to IDLE.
- Load-after-store to the same address sees the stored data, because the transactions are strictly serialized.

Optional Feature:
- DMEM_WSTRB_EN defined:
  - Adds input req_wstrb [7:0].
  - A store writes only the bytes whose strobe bit is 1; the other bytes are unchanged.
  - Loads ignore the strobe.
  - A store with strobe 8'h00 completes normally with no data change.
- DMEM_WSTRB_EN undefined: the port is absent and every store writes all 8 bytes.

Decomposition:
- Package dmem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - DWORD_BYTES=8;
  - ALIGN_BITS=3;
  - the default LATENCY constant.
- Sub-module dmem_array: byte storage with a synchronous 8-byte write (optional strobe), combinational 8-byte read, and async active-low clear.
- dmem_responder keeps the FSM, the counter and the response registers.

Test Plan:
- Reset then idle → req_ready=1, rsp_valid=0, rsp_rdata=0; a load of addr 0x010 returns 64'h0.
- Store 0x1122334455667788 to 0x008, then load 0x008 with rsp_ready=1 → rsp_valid exactly 2 cycles after each accept; load returns 0x1122334455667788, rsp_err=0; a byte view confirms mem[0x008]=0x88.
- Load from 0x00C (misaligned) → rsp_err=1, rsp_rdata=0; a following load of 0x008 still returns the prior stored value.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready=0, a concurrent req_valid ignored; accepted one cycle after rsp_ready=1.
- Drive reset low one cycle before the commit edge of a store of 0xDEAD to 0x020 → outputs return to reset values; a later load of 0x020 returns 0.
- With DMEM_WSTRB_EN defined: store all-ones with wstrb=8'h0F over zeros at 0x030 → load returns 0x00000000FFFFFFFF.
